// File: rtl/quick_sort_frame_ctrl.sv
// Frame sequencer around the quick-sort engine: loads a frame into the shared RAM,
// kicks the engine over [0, N-1], then streams the sorted words back out.
module quick_sort_frame_ctrl #(
   parameter int unsigned WORD_SIZE  = 16,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WORD_SIZE-1:0]  in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [WORD_SIZE-1:0]  out_data,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  sort_start,
   output logic [WORD_SIZE-1:0]  sort_lo,
   output logic [WORD_SIZE-1:0]  sort_hi,
   input  logic                  sort_done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WORD_SIZE-1:0]  mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic [WORD_SIZE-1:0]  mem_rdata,
   output logic                  busy,
   output logic [ADDR_WIDTH:0]   frame_len
);

   localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_LOAD,
      S_SORT_START,
      S_SORT_WAIT,
      S_UNLOAD_RD,
      S_UNLOAD_CAP,
      S_UNLOAD_HOLD
   } state_t;

   state_t                 state, state_nxt;
   logic [ADDR_WIDTH-1:0]  count, count_nxt;
   logic [ADDR_WIDTH-1:0]  rd_idx, rd_idx_nxt;
   logic [LEN_WIDTH-1:0]   frame_len_nxt;
   logic [WORD_SIZE-1:0]   sort_hi_nxt;
   logic [WORD_SIZE-1:0]   out_data_nxt;
   logic                   out_valid_nxt;
   logic                   out_last_nxt;

   // Engine always sorts from the bottom of the array.
   assign sort_lo = '0;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_LOAD;
         count     <= '0;
         rd_idx    <= '0;
         frame_len <= '0;
         sort_hi   <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         rd_idx    <= rd_idx_nxt;
         frame_len <= frame_len_nxt;
         sort_hi   <= sort_hi_nxt;
         out_data  <= out_data_nxt;
         out_valid <= out_valid_nxt;
         out_last  <= out_last_nxt;
      end
   end

   // Next-state, next-register values and combinational RAM/stream controls.
   always_comb begin
      state_nxt     = state;
      count_nxt     = count;
      rd_idx_nxt    = rd_idx;
      frame_len_nxt = frame_len;
      sort_hi_nxt   = sort_hi;
      out_data_nxt  = out_data;
      out_valid_nxt = out_valid;
      out_last_nxt  = out_last;
      in_ready      = 1'b0;
      sort_start    = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_we        = 1'b0;
      mem_re        = 1'b0;

      case (state)
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mem_we    = 1'b1;
               mem_addr  = count;
               mem_wdata = in_data;
               count_nxt = count + ADDR_WIDTH'(1);
               // Frame closes on in_last or when the array is full.
               if (in_last || (count == LAST_IDX)) begin
                  frame_len_nxt = LEN_WIDTH'(count) + LEN_WIDTH'(1);
                  sort_hi_nxt   = WORD_SIZE'(count);
                  rd_idx_nxt    = '0;
                  state_nxt     = (count == '0) ? S_UNLOAD_RD : S_SORT_START;
               end
            end
         end

         S_SORT_START: begin
            sort_start = 1'b1;
            state_nxt  = S_SORT_WAIT;
         end

         S_SORT_WAIT: begin
            if (sort_done) begin
               state_nxt = S_UNLOAD_RD;
            end
         end

         S_UNLOAD_RD: begin
            mem_re    = 1'b1;
            mem_addr  = rd_idx;
            state_nxt = S_UNLOAD_CAP;
         end

         S_UNLOAD_CAP: begin
            out_data_nxt  = mem_rdata;
            out_valid_nxt = 1'b1;
            out_last_nxt  = (LEN_WIDTH'(rd_idx) + LEN_WIDTH'(1)) == frame_len;
            state_nxt     = S_UNLOAD_HOLD;
         end

         S_UNLOAD_HOLD: begin
            if (out_ready) begin
               out_valid_nxt = 1'b0;
               if (out_last) begin
                  count_nxt  = '0;
                  rd_idx_nxt = '0;
                  state_nxt  = S_LOAD;
               end else begin
                  rd_idx_nxt = rd_idx + ADDR_WIDTH'(1);
                  state_nxt  = S_UNLOAD_RD;
               end
            end
         end

         default: begin
            state_nxt = S_LOAD;
         end
      endcase

      busy = !((state == S_LOAD) && (count == '0));
   end

endmodule

// File: tb/tb_quick_sort_frame_ctrl.sv
// Directed bench for quick_sort_frame_ctrl with a RAM + sort-engine model and
// a scoreboard of expected sorted output words.
module tb_quick_sort_frame_ctrl;

   localparam int unsigned W  = 16;
   localparam int unsigned D  = 32;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          in_ready;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_last;
   logic          out_ready = 1'b0;
   logic          sort_start;
   logic [W-1:0]  sort_lo;
   logic [W-1:0]  sort_hi;
   logic          sort_done;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_wdata;
   logic          mem_we;
   logic          mem_re;
   logic [W-1:0]  mem_rdata = '0;
   logic          busy;
   logic [AW:0]   frame_len;

   quick_sort_frame_ctrl #(.WORD_SIZE(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .sort_start(sort_start), .sort_lo(sort_lo), .sort_hi(sort_hi), .sort_done(sort_done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .busy(busy), .frame_len(frame_len)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [W-1:0] data; logic last; } exp_t;
   typedef logic [W-1:0] mem_t [D];

   exp_t    sb[$];
   mem_t    ram;
   int      checks = 0;
   int      failures = 0;
   int      eng_cnt = 0;
   int      starts = 0;
   int      we_cnt = 0;
   int      re_cnt = 0;
   int      overlap = 0;
   logic [W-1:0] eng_hi = '0;
   logic    engine_done = 1'b0;
   logic    manual_done = 1'b0;

   assign sort_done = engine_done | manual_done;

   function automatic mem_t sort_mem(input mem_t m, input int hi);
      mem_t r;
      logic [W-1:0] t;
      r = m;
      for (int i = 1; i <= hi; i++)
         for (int j = i; j > 0; j--)
            if (r[j-1] > r[j]) begin t = r[j]; r[j] = r[j-1]; r[j-1] = t; end
      return r;
   endfunction

   // RAM with one-cycle read latency plus a sort engine that finishes 10 cycles after start.
   always @(posedge clk) begin
      engine_done <= 1'b0;
      if (mem_we) begin ram[mem_addr] <= mem_wdata; we_cnt <= we_cnt + 1; end
      if (mem_re) begin mem_rdata <= ram[mem_addr]; re_cnt <= re_cnt + 1; end
      if (mem_we && mem_re) overlap <= overlap + 1;
      if (!rst_n) eng_cnt <= 0;
      else if (sort_start) begin
         eng_cnt <= 10;
         starts  <= starts + 1;
         eng_hi  <= sort_hi;
      end else if (eng_cnt == 1) begin
         ram         <= sort_mem(ram, int'(eng_hi));
         engine_done <= 1'b1;
         eng_cnt     <= 0;
      end else if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [W-1:0] f[$]);
      logic [W-1:0] a[$];
      logic [W-1:0] t;
      exp_t e;
      a = f;
      for (int i = 1; i < a.size(); i++)
         for (int j = i; j > 0; j--)
            if (a[j-1] > a[j]) begin t = a[j]; a[j] = a[j-1]; a[j-1] = t; end
      for (int i = 0; i < a.size(); i++) begin
         e.data = a[i];
         e.last = (i == a.size() - 1);
         sb.push_back(e);
      end
   endtask

   // Called at a negedge; returns at the negedge after the word is accepted.
   task automatic send_word(input logic [W-1:0] d, input logic last, input int addr, input int gap);
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int g = 0; g < gap; g++) begin
         #1 chk("idle_no_we", 32'(mem_we), 32'd0);
         @(negedge clk);
      end
      in_data  = d;
      in_valid = 1'b1;
      in_last  = last;
      #1;
      chk("in_ready", 32'(in_ready), 32'd1);
      chk("mem_we", 32'(mem_we), 32'd1);
      chk("mem_addr", 32'(mem_addr), 32'(addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(d));
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic load_frame(input logic [W-1:0] f[$], input int max_gap, input bit do_push);
      if (do_push) push_exp(f);
      for (int i = 0; i < f.size(); i++)
         send_word(f[i], 1'(i == f.size() - 1), i,
                   (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
   endtask

   task automatic drain(input int n, input int stall_idx, input int stall_cycles, input int first_gap);
      exp_t e;
      int   waited;
      int   re0;
      for (int k = 0; k < n; k++) begin
         waited = 0;
         while (out_valid !== 1'b1 && waited < 60) begin @(negedge clk); waited++; end
         chk("out_valid_seen", 32'(out_valid), 32'd1);
         if (k > 0) chk("word_gap", 32'(waited), 32'd2);
         else if (first_gap >= 0) chk("first_latency", 32'(waited), 32'(first_gap));
         e = '0;
         if (sb.size() > 0) e = sb.pop_front();
         chk("out_data", 32'(out_data), 32'(e.data));
         chk("out_last", 32'(out_last), 32'(e.last));
         if (k == stall_idx) begin
            re0 = re_cnt;
            for (int s = 0; s < stall_cycles; s++) begin
               manual_done = (s == 0);
               @(negedge clk);
               manual_done = 1'b0;
               chk("stall_valid", 32'(out_valid), 32'd1);
               chk("stall_data", 32'(out_data), 32'(e.data));
               chk("stall_last", 32'(out_last), 32'(e.last));
            end
            chk("stall_no_re", 32'(re_cnt - re0), 32'd0);
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk("valid_drop", 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      logic [W-1:0] f[$];
      logic [W-1:0] big[$];
      int s0, w0, r0, len;
      bit quiet;

      // Reset
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sort_start", 32'(sort_start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_len", 32'(frame_len), 32'd0);
      chk("rst_sort_hi", 32'(sort_hi), 32'd0);
      chk("rst_mem_re", 32'(mem_re), 32'd0);
      @(negedge clk);

      // Five-word frame, with input attempted while the engine runs
      s0 = starts; w0 = we_cnt; r0 = re_cnt;
      f = {16'd9, 16'd3, 16'd7, 16'd1, 16'd5};
      load_frame(f, 0, 1'b1);
      chk("t1_sort_start", 32'(sort_start), 32'd1);
      chk("t1_sort_lo", 32'(sort_lo), 32'd0);
      chk("t1_sort_hi", 32'(sort_hi), 32'd4);
      chk("t1_frame_len", 32'(frame_len), 32'd5);
      chk("t1_in_ready_low", 32'(in_ready), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t1_start_one_cycle", 32'(sort_start), 32'd0);
      in_data = 16'd77; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("wait_in_ready", 32'(in_ready), 32'd0);
         chk("wait_no_we", 32'(mem_we), 32'd0);
         chk("wait_no_re", 32'(mem_re), 32'd0);
         chk("wait_hi_stable", 32'(sort_hi), 32'd4);
         @(negedge clk);
      end
      in_valid = 1'b0;
      drain(5, -1, 0, -1);
      chk("t1_starts", 32'(starts - s0), 32'd1);
      chk("t1_we_count", 32'(we_cnt - w0), 32'd5);
      chk("t1_re_count", 32'(re_cnt - r0), 32'd5);
      chk("t1_back_to_load", 32'(in_ready), 32'd1);
      chk("t1_idle_busy", 32'(busy), 32'd0);

      // Single-word frame bypasses the engine
      s0 = starts;
      f = {16'd42};
      load_frame(f, 0, 1'b1);
      chk("t2_no_start", 32'(sort_start), 32'd0);
      chk("t2_mem_re", 32'(mem_re), 32'd1);
      chk("t2_mem_addr", 32'(mem_addr), 32'd0);
      chk("t2_frame_len", 32'(frame_len), 32'd1);
      drain(1, -1, 0, 2);
      chk("t2_starts", 32'(starts - s0), 32'd0);

      // Overlong stream: capped at DEPTH, remainder becomes the next frame
      big = {};
      for (int i = 0; i < 34; i++) big.push_back(W'($urandom));
      f = big[0:31];
      push_exp(f);
      w0 = we_cnt;
      for (int i = 0; i < 32; i++) send_word(big[i], 1'b0, i, 0);
      in_data = big[32]; in_valid = 1'b1;
      #1;
      chk("t3_in_ready_low", 32'(in_ready), 32'd0);
      chk("t3_no_we", 32'(mem_we), 32'd0);
      chk("t3_sort_start", 32'(sort_start), 32'd1);
      chk("t3_sort_hi", 32'(sort_hi), 32'd31);
      chk("t3_frame_len", 32'(frame_len), 32'd32);
      drain(32, -1, 0, -1);
      chk("t3_we_count", 32'(we_cnt - w0), 32'd32);
      #1;
      chk("t3_w33_ready", 32'(in_ready), 32'd1);
      chk("t3_w33_we", 32'(mem_we), 32'd1);
      chk("t3_w33_addr", 32'(mem_addr), 32'd0);
      chk("t3_w33_data", 32'(mem_wdata), 32'(big[32]));
      f = {big[32], big[33]};
      push_exp(f);
      @(negedge clk);
      send_word(big[33], 1'b1, 1, 0);
      chk("t3b_sort_hi", 32'(sort_hi), 32'd1);
      chk("t3b_frame_len", 32'(frame_len), 32'd2);
      drain(2, -1, 0, -1);

      // Spurious sort_done while idle in LOAD is ignored
      manual_done = 1'b1;
      @(negedge clk);
      manual_done = 1'b0;
      #1;
      chk("t5_load_ready", 32'(in_ready), 32'd1);
      chk("t5_load_busy", 32'(busy), 32'd0);
      chk("t5_load_no_re", 32'(mem_re), 32'd0);
      @(negedge clk);

      // Input gaps plus a 7-cycle output stall with a spurious sort_done
      r0 = re_cnt;
      f = {16'd400, 16'd12, 16'd12, 16'd3};
      load_frame(f, 3, 1'b1);
      chk("t4_sort_hi", 32'(sort_hi), 32'd3);
      drain(4, 1, 7, -1);
      chk("t4_re_count", 32'(re_cnt - r0), 32'd4);

      // Random frames
      for (int r = 0; r < 2; r++) begin
         len = int'($urandom_range(9, 2));
         f = {};
         for (int i = 0; i < len; i++) f.push_back(W'($urandom));
         load_frame(f, 2, 1'b1);
         chk("rand_sort_hi", 32'(sort_hi), 32'(len - 1));
         drain(len, -1, 0, -1);
      end

      // Reset while the engine is running abandons the frame
      f = {16'd11, 16'd4, 16'd8, 16'd2};
      load_frame(f, 0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t6_in_ready", 32'(in_ready), 32'd1);
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      chk("t6_sort_start", 32'(sort_start), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_frame_len", 32'(frame_len), 32'd0);
      quiet = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
      end
      chk("t6_stays_idle", 32'(quiet), 32'd1);
      f = {16'd300, 16'd100, 16'd200};
      load_frame(f, 0, 1'b1);
      chk("t6_sort_start_new", 32'(sort_start), 32'd1);
      chk("t6_sort_hi", 32'(sort_hi), 32'd2);
      drain(3, -1, 0, -1);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("no_we_re_overlap", 32'(overlap), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
